// File: rtl/ysyx_22041071_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU read arbiter: FSM encoding, grant
// owner, AXI IDs, transfer-size codes and response codes.
package ysyx_22041071_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;

  localparam int IFU_ID = 0;
  localparam int LSU_ID = 1;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22041071_rd_arbiter_if.sv
// Bundle of the IFU request/response, LSU request/response and read-master
// request/completion signals. The "master" modport is the arbiter's view;
// "slave" is the view of whatever sits on the other side of all three.
//
// Handshake rules: a requester raises x_req_valid and holds it, with stable
// address/attributes, until the cycle in which x_req_ready is also high; the
// transfer happens on that clock edge. x_rsp_valid is a single-cycle pulse
// with no back-pressure. cpu_ar_valid stays high until cpu_ar_ready; a read
// completes only on cpu_ar_ready & cpu_r_valid, since cpu_r_valid is sticky.
interface ysyx_22041071_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_rsp_valid;
  logic [31:0]       ifu_rsp_inst;
  logic [1:0]        ifu_rsp_resp;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [1:0]        lsu_req_size;
  logic              lsu_req_unsigned;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rsp_data;
  logic [1:0]        lsu_rsp_resp;

  logic              cpu_ar_valid;
  logic              cpu_ar_ready;
  logic [ID_W-1:0]   cpu_id;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_len;
  logic [1:0]        cpu_size;
  logic              cpu_r_valid;
  logic [DATA_W-1:0] cpu_r_data;
  logic [1:0]        cpu_r_resp;

  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_resp,
    input  lsu_req_valid, lsu_req_addr, lsu_req_size, lsu_req_unsigned,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_resp,
    output cpu_ar_valid, cpu_id, cpu_addr, cpu_len, cpu_size,
    input  cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_resp,
    output lsu_req_valid, lsu_req_addr, lsu_req_size, lsu_req_unsigned,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_resp,
    input  cpu_ar_valid, cpu_id, cpu_addr, cpu_len, cpu_size,
    output cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_r_resp
  );
endinterface

// File: rtl/ysyx_22041071_ld_align.sv
// Load-data aligner: shifts the 64-bit read beat down by the byte offset,
// keeps 1/2/4/8 bytes and sign- or zero-extends. Purely combinational so the
// write-back path can reuse the same block.
module ysyx_22041071_ld_align
  import ysyx_22041071_rd_arbiter_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Shift selected bytes to lane 0, then truncate and extend by size.
  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = shifted;
    case (size)
      SIZE_B:  result = is_unsigned ? {56'd0, shifted[7:0]}
                                    : {{56{shifted[7]}}, shifted[7:0]};
      SIZE_H:  result = is_unsigned ? {48'd0, shifted[15:0]}
                                    : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W:  result = is_unsigned ? {32'd0, shifted[31:0]}
                                    : {{32{shifted[31]}}, shifted[31:0]};
      SIZE_D:  result = shifted;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22041071_rd_arbiter.sv
// Two-master (IFU/LSU) single-beat read arbiter in front of the AXI read
// master. Round-robin on ties, one transaction in flight, request attributes
// held from grant until the response cycle ends.
// Optional watchdog: define YSYX_22041071_RD_TIMEOUT_EN to abort a stuck
// ISSUE/WAIT after TIMEOUT_CYC cycles with a DECERR response and zero data.
module ysyx_22041071_rd_arbiter
  import ysyx_22041071_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4
`ifdef YSYX_22041071_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic   clk,
  input  logic   reset,
  ysyx_22041071_rd_arbiter_if.master bus,
  output state_t state
);

  localparam logic [ID_W-1:0] ID_IFU = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] ID_LSU = ID_W'(LSU_ID);

  state_t            state_q, state_d;
  grant_t            last_grant_q, owner_q;
  logic              grant_ifu, grant_lsu, req_fire;
  logic              r_strobe, tmo_hit, rsp_load, rsp_err;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [ID_W-1:0]   id_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] cap_data;
  logic [1:0]        cap_resp;
  logic [63:0]       ld_result;
  logic [31:0]       ifu_inst_q;
  logic [1:0]        ifu_resp_q;
  logic [DATA_W-1:0] lsu_data_q;
  logic [1:0]        lsu_resp_q;

  // Grant in IDLE: a lone requester wins; on a tie the one not served last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_ifu = (last_grant_q == GNT_LSU);
        grant_lsu = (last_grant_q == GNT_IFU);
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
    end
  end

  assign req_fire = grant_ifu | grant_lsu;
  // r_valid is sticky from older reads; ar_ready qualifies this read's beat.
  assign r_strobe = (state_q == S_WAIT) && bus.cpu_ar_ready && bus.cpu_r_valid;

`ifdef YSYX_22041071_RD_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  // Watchdog counts ISSUE/WAIT residency and restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_WAIT) &&
                   (tmo_cnt_q == 8'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a real handshake or data beat takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire) state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus.cpu_ar_ready) state_d = S_WAIT;
        else if (tmo_hit)     state_d = S_RESP;
      end
      S_WAIT:  if (r_strobe || tmo_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-driven outputs: request ready, AR valid and the response pulses.
  always_comb begin
    bus.ifu_req_ready = grant_ifu;
    bus.lsu_req_ready = grant_lsu;
    bus.cpu_ar_valid  = (state_q == S_ISSUE);
    bus.ifu_rsp_valid = (state_q == S_RESP) && (owner_q == GNT_IFU);
    bus.lsu_rsp_valid = (state_q == S_RESP) && (owner_q == GNT_LSU);
  end

  // Response is loaded on entry to RESP; anything but a data beat is an abort.
  assign rsp_load = (state_d == S_RESP) && (state_q != S_RESP);
  assign rsp_err  = !r_strobe;
  assign cap_data = rsp_err ? '0 : bus.cpu_r_data;
  assign cap_resp = rsp_err ? RESP_DECERR : bus.cpu_r_resp;

  ysyx_22041071_ld_align u_ld_align (
    .data        (cap_data),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (ld_result)
  );

  // Latch the winner's request on handshake; held until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      size_q       <= '0;
      id_q         <= '0;
      unsigned_q   <= 1'b0;
      owner_q      <= GNT_IFU;
      last_grant_q <= GNT_LSU;
    end else if (req_fire) begin
      if (grant_ifu) begin
        addr_q       <= bus.ifu_req_addr;
        size_q       <= SIZE_W;
        id_q         <= ID_IFU;
        unsigned_q   <= 1'b1;
        owner_q      <= GNT_IFU;
        last_grant_q <= GNT_IFU;
      end else begin
        addr_q       <= bus.lsu_req_addr;
        size_q       <= bus.lsu_req_size;
        id_q         <= ID_LSU;
        unsigned_q   <= bus.lsu_req_unsigned;
        owner_q      <= GNT_LSU;
        last_grant_q <= GNT_LSU;
      end
    end
  end

  // Capture the owner's response data; the other side keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_inst_q <= '0;
      ifu_resp_q <= '0;
      lsu_data_q <= '0;
      lsu_resp_q <= '0;
    end else if (rsp_load) begin
      if (owner_q == GNT_IFU) begin
        ifu_inst_q <= addr_q[2] ? cap_data[63:32] : cap_data[31:0];
        ifu_resp_q <= cap_resp;
      end else begin
        lsu_data_q <= ld_result;
        lsu_resp_q <= cap_resp;
      end
    end
  end

  assign bus.cpu_addr     = addr_q;
  assign bus.cpu_size     = size_q;
  assign bus.cpu_id       = id_q;
  assign bus.cpu_len      = 8'd0;
  assign bus.ifu_rsp_inst = ifu_inst_q;
  assign bus.ifu_rsp_resp = ifu_resp_q;
  assign bus.lsu_rsp_data = lsu_data_q;
  assign bus.lsu_rsp_resp = lsu_resp_q;
  assign state            = state_q;

endmodule

// File: tb/tb_ysyx_22041071_rd_arbiter.sv
// Bench for the IFU/LSU read arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level model of the arbiter and a
// behavioural read master. Define YSYX_22041071_RD_TIMEOUT_EN to add the
// watchdog scenario.
`timescale 1ns/1ps
module tb_ysyx_22041071_rd_arbiter;
  import ysyx_22041071_rd_arbiter_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int TMO    = 255;

  logic   clk = 1'b0;
  logic   reset;
  state_t state;

  ysyx_22041071_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  ysyx_22041071_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: sim time %0t exceeded, required completion", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected responses: {owner_is_lsu, resp[1:0], data[63:0]}
  logic [66:0] exp_q[$];

  // ---------------- model state ----------------
  int          phase;        // 0 idle, 1 issue, 2 wait, 3 response due, 4 response cycle
  bit          own_lsu;
  bit          last_lsu;
  logic [63:0] m_addr;
  logic [1:0]  m_size;
  bit          m_uns;
  int          stall_cnt, wait_cnt;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [31:0] last_inst;
  logic [1:0]  last_ifu_resp;
  logic [63:0] last_lsu_data;
  logic [1:0]  last_lsu_resp;
  bit          ifu_acc, lsu_acc;
  bit          grant_log[$];
  int          cyc, hs_cyc, rsp_cyc, n_rsp, ar_valid_cnt;

  // Stimulus knobs
  bit          rand_en;
  int          ifu_left, lsu_left;
  logic [63:0] d_ifu_addr, d_lsu_addr;
  logic [1:0]  d_lsu_size;
  bit          d_lsu_uns;
  bit          force_data_en;
  logic [63:0] force_data;
  int          force_stall, force_wait;

  // Reference load result from byte arithmetic.
  function automatic logic [63:0] ref_load(logic [63:0] d, logic [2:0] off,
                                           logic [1:0] size, bit uns);
    int          nbytes;
    logic [63:0] v, mask;
    nbytes = 1 << size;
    v      = d >> (int'(off) * 8);
    mask   = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (nbytes * 8)) - 64'd1);
    v      = v & mask;
    if (!uns && v[nbytes*8-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_clear();
    phase = 0; own_lsu = 0; last_lsu = 1; m_addr = '0; m_size = '0; m_uns = 0;
    stall_cnt = 0; wait_cnt = 0; last_inst = '0; last_ifu_resp = '0;
    last_lsu_data = '0; last_lsu_resp = '0; ifu_acc = 0; lsu_acc = 0;
    exp_q.delete();
    ifu_left = 0; lsu_left = 0; rand_en = 0;
    force_data_en = 0; force_stall = -1; force_wait = -1;
  endtask

  task automatic drive_idle();
    bus.ifu_req_valid = 0; bus.ifu_req_addr = '0;
    bus.lsu_req_valid = 0; bus.lsu_req_addr = '0;
    bus.lsu_req_size = '0; bus.lsu_req_unsigned = 0;
    bus.cpu_ar_ready = 0; bus.cpu_r_valid = 0; bus.cpu_r_data = '0; bus.cpu_r_resp = '0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_state"},     64'(state), 64'(S_IDLE));
    check({pfx, "_ifu_ready"}, 64'(bus.ifu_req_ready), 0);
    check({pfx, "_lsu_ready"}, 64'(bus.lsu_req_ready), 0);
    check({pfx, "_ar_valid"},  64'(bus.cpu_ar_valid), 0);
    check({pfx, "_cpu_addr"},  bus.cpu_addr, 0);
    check({pfx, "_cpu_id"},    64'(bus.cpu_id), 0);
    check({pfx, "_cpu_size"},  64'(bus.cpu_size), 0);
    check({pfx, "_ifu_rspv"},  64'(bus.ifu_rsp_valid), 0);
    check({pfx, "_lsu_rspv"},  64'(bus.lsu_rsp_valid), 0);
    check({pfx, "_ifu_inst"},  64'(bus.ifu_rsp_inst), 0);
    check({pfx, "_lsu_data"},  bus.lsu_rsp_data, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    drive_idle();
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 0;
    bus.cpu_ar_ready = 1;
    @(negedge clk);
  endtask

  // ---------------- driver: one cycle at the falling edge ----------------
  task automatic cycle();
    logic [66:0] e;
    logic [63:0] exp_data;
    bit          w_ifu, w_lsu;
    cyc++;
    // 1) check outputs for the state reached at the last rising edge
    check("ifu_rsp_valid", 64'(bus.ifu_rsp_valid), 64'(phase == 3 && !own_lsu));
    check("lsu_rsp_valid", 64'(bus.lsu_rsp_valid), 64'(phase == 3 && own_lsu));
    check("cpu_ar_valid",  64'(bus.cpu_ar_valid),  64'(phase == 1));
    check("cpu_len",       64'(bus.cpu_len), 0);
    if (bus.cpu_ar_valid) ar_valid_cnt++;
    if (phase != 0) begin
      check("cpu_addr_hold", bus.cpu_addr, m_addr);
      check("cpu_id_hold",   64'(bus.cpu_id), 64'(own_lsu ? LSU_ID : IFU_ID));
      check("cpu_size_hold", 64'(bus.cpu_size), 64'(m_size));
    end
    if (phase == 3) begin
      rsp_cyc = cyc;
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (!e[66]) begin last_inst = e[31:0]; last_ifu_resp = e[65:64]; end
        else        begin last_lsu_data = e[63:0]; last_lsu_resp = e[65:64]; end
      end
      phase = 4;
    end
    check("ifu_rsp_inst", 64'(bus.ifu_rsp_inst), 64'(last_inst));
    check("ifu_rsp_resp", 64'(bus.ifu_rsp_resp), 64'(last_ifu_resp));
    check("lsu_rsp_data", bus.lsu_rsp_data, last_lsu_data);
    check("lsu_rsp_resp", 64'(bus.lsu_rsp_resp), 64'(last_lsu_resp));

    // 2) drive requests and the read master for the coming edge
    if (ifu_acc) begin bus.ifu_req_valid = 0; ifu_acc = 0; end
    if (lsu_acc) begin bus.lsu_req_valid = 0; lsu_acc = 0; end
    if (!bus.ifu_req_valid) begin
      if (ifu_left > 0) begin
        ifu_left--; bus.ifu_req_valid = 1; bus.ifu_req_addr = d_ifu_addr;
      end else if (rand_en && $urandom_range(0, 2) == 0) begin
        bus.ifu_req_valid = 1;
        bus.ifu_req_addr = {$urandom, $urandom};
        bus.ifu_req_addr[1:0] = 2'b00;
      end
    end
    if (!bus.lsu_req_valid) begin
      if (lsu_left > 0) begin
        lsu_left--; bus.lsu_req_valid = 1; bus.lsu_req_addr = d_lsu_addr;
        bus.lsu_req_size = d_lsu_size; bus.lsu_req_unsigned = d_lsu_uns;
      end else if (rand_en && $urandom_range(0, 2) == 0) begin
        bus.lsu_req_valid = 1;
        bus.lsu_req_size = 2'($urandom_range(0, 3));
        bus.lsu_req_unsigned = 1'($urandom_range(0, 1));
        bus.lsu_req_addr = {$urandom, $urandom};
        bus.lsu_req_addr[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << bus.lsu_req_size) - 1);
      end
    end
    bus.cpu_r_data = {$urandom, $urandom};
    case (phase)
      1: if (stall_cnt > 0) begin bus.cpu_ar_ready = 0; stall_cnt--; end
         else bus.cpu_ar_ready = 1;
      2: if (wait_cnt > 0) begin bus.cpu_ar_ready = 0; wait_cnt--; end
         else begin
           bus.cpu_ar_ready = 1; bus.cpu_r_valid = 1;
           bus.cpu_r_data = m_rdata; bus.cpu_r_resp = m_rresp;
         end
      default: bus.cpu_ar_ready = 1;
    endcase

    // 3) let combinational outputs settle
    #1;

    // 4) predict what the coming rising edge does
    if (phase == 0) begin
      w_ifu = 0; w_lsu = 0;
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        w_ifu = last_lsu; w_lsu = !last_lsu;
      end else begin
        w_ifu = bus.ifu_req_valid; w_lsu = bus.lsu_req_valid;
      end
      check("ifu_req_ready", 64'(bus.ifu_req_ready), 64'(w_ifu));
      check("lsu_req_ready", 64'(bus.lsu_req_ready), 64'(w_lsu));
      if (w_ifu || w_lsu) begin
        own_lsu = w_lsu; last_lsu = w_lsu; grant_log.push_back(w_lsu);
        hs_cyc = cyc; phase = 1;
        if (w_ifu) begin
          m_addr = bus.ifu_req_addr; m_size = SIZE_W; m_uns = 1; ifu_acc = 1;
        end else begin
          m_addr = bus.lsu_req_addr; m_size = bus.lsu_req_size;
          m_uns = bus.lsu_req_unsigned; lsu_acc = 1;
        end
        stall_cnt = (force_stall >= 0) ? force_stall : $urandom_range(0, 2);
      end
    end else begin
      check("ifu_req_ready_busy", 64'(bus.ifu_req_ready), 0);
      check("lsu_req_ready_busy", 64'(bus.lsu_req_ready), 0);
      if (phase == 4) begin
        phase = 0;
      end else if (phase == 1 && bus.cpu_ar_ready) begin
        phase = 2;
        wait_cnt = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
        m_rdata  = force_data_en ? force_data : {$urandom, $urandom};
        m_rresp  = force_data_en ? RESP_OKAY : 2'($urandom_range(0, 3));
        exp_data = own_lsu ? ref_load(m_rdata, m_addr[2:0], m_size, m_uns)
                           : {32'd0, (m_addr[2] ? m_rdata[63:32] : m_rdata[31:0])};
        exp_q.push_back({own_lsu, m_rresp, exp_data});
      end else if (phase == 2 && bus.cpu_ar_ready && bus.cpu_r_valid) begin
        phase = 3;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(phase == 0 && ifu_left == 0 && lsu_left == 0 &&
             !ifu_acc && !lsu_acc && !bus.ifu_req_valid && !bus.lsu_req_valid) &&
           n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check({tag, "_budget"}, 1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    cyc = 0; n_rsp = 0; ar_valid_cnt = 0; hs_cyc = 0; rsp_cyc = 0;
    @(negedge clk);
    do_reset();

    // T1: IFU fetch from upper word, minimum latency
    force_stall = 0; force_wait = 0; force_data_en = 1;
    force_data = 64'h1122_3344_5566_7788;
    d_ifu_addr = 64'h0000_0000_8000_0004; ifu_left = 1;
    run_until_idle("t1", 30);
    check("t1_inst",    64'(bus.ifu_rsp_inst), 64'h1122_3344);
    check("t1_latency", 64'(rsp_cyc - hs_cyc), 3);

    // T2: signed then unsigned byte load from offset 3
    force_data = 64'h0000_0000_8000_0000;
    d_lsu_addr = 64'h0000_0000_8000_0003; d_lsu_size = SIZE_B; d_lsu_uns = 0; lsu_left = 1;
    run_until_idle("t2s", 30);
    check("t2_signed",   bus.lsu_rsp_data, 64'hFFFF_FFFF_FFFF_FF80);
    d_lsu_uns = 1; lsu_left = 1;
    run_until_idle("t2u", 30);
    check("t2_unsigned", bus.lsu_rsp_data, 64'h0000_0000_0000_0080);

    // T3: both requesters continuously valid -> strict alternation
    force_stall = -1; force_wait = -1; force_data_en = 0;
    grant_log.delete();
    d_ifu_addr = 64'h0000_0000_8000_1000; d_lsu_addr = 64'h0000_0000_8000_2004;
    d_lsu_size = SIZE_W; d_lsu_uns = 0;
    ifu_left = 4; lsu_left = 4;
    run_until_idle("t3", 200);
    check("t3_grants", 64'(grant_log.size()), 8);
    foreach (grant_log[i]) check($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // T4: master stalls AR for 10 cycles in ISSUE
    force_stall = 10; ar_valid_cnt = 0;
    d_ifu_addr = 64'h0000_0000_8000_3008; ifu_left = 1;
    run_until_idle("t4", 60);
    check("t4_ar_cycles", 64'(ar_valid_cnt), 11);
    force_stall = -1;

    // T5: asynchronous reset while waiting for data
    force_wait = 8;
    d_lsu_addr = 64'h0000_0000_8000_4000; d_lsu_size = SIZE_D; lsu_left = 1;
    n = 0;
    while (phase != 2 && n < 20) begin cycle(); n++; end
    check("t5_reach_wait", 64'(phase), 2);
    cycle(); cycle();
    #2;
    reset = 1;
    drive_idle();
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    model_clear();
    reset = 0;
    bus.cpu_ar_ready = 1;
    repeat (10) cycle();

    // Randomized traffic
    rand_en = 1;
    n = 0;
    begin
      int start_rsp;
      start_rsp = n_rsp;
      while (n_rsp < start_rsp + 80 && n < 3000) begin cycle(); n++; end
      check("rand_progress", 64'(n_rsp >= start_rsp + 80), 1);
    end
    rand_en = 0;
    run_until_idle("rand_drain", 100);

`ifdef YSYX_22041071_RD_TIMEOUT_EN
    // T6: read master never completes -> watchdog DECERR
    begin
      int k;
      do_reset();
      bus.cpu_r_valid = 1;
      bus.lsu_req_valid = 1; bus.lsu_req_addr = 64'h0000_0000_8000_5000;
      bus.lsu_req_size = SIZE_D; bus.lsu_req_unsigned = 0;
      @(negedge clk);
      bus.lsu_req_valid = 0;
      @(negedge clk);
      bus.cpu_ar_ready = 0;
      k = 0;
      while (!bus.lsu_rsp_valid && k < 600) begin
        @(negedge clk);
        k++;
      end
      check("t6_seen",   64'(bus.lsu_rsp_valid), 1);
      check("t6_window", 64'(k >= TMO && k <= TMO + 2), 1);
      check("t6_resp",   64'(bus.lsu_rsp_resp), 64'(RESP_DECERR));
      check("t6_data",   bus.lsu_rsp_data, 0);
      @(negedge clk);
      check("t6_idle", 64'(state), 64'(S_IDLE));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_rd_arbiter.md
Name: ysyx_22041071_rd_arbiter

Overview:
Two-master read arbiter sitting directly upstream of the AXI read-channel master. It arbitrates instruction-fetch (IFU) and load (LSU) single-beat read requests, drives the master's cpu_* request side, and holds the address stable for the whole transaction. It detects completion and returns aligned data to the winning requester: a 32-bit instruction to the IFU, sign/zero-extended load data to the LSU. One outstanding transaction at a time.

Parameters:
ADDR_W, 64, request address width
DATA_W, 64, AXI data width
ID_W, 4, AXI ID width; IFU uses ID 0, LSU uses ID 1
TIMEOUT_CYC, 255, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ifu_req_valid/ifu_req_ready  in/out  1/1  IFU request handshake
ifu_req_addr  in  ADDR_W  fetch address, 4-byte aligned
ifu_rsp_valid  out  1  one-cycle response pulse
ifu_rsp_inst  out  32  instruction word
ifu_rsp_resp  out  2  AXI response
lsu_req_valid/lsu_req_ready  in/out  1/1  LSU request handshake
lsu_req_addr  in  ADDR_W  load address
lsu_req_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
lsu_req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
lsu_rsp_valid  out  1  one-cycle response pulse
lsu_rsp_data  out  DATA_W  aligned, extended load data
lsu_rsp_resp  out  2  AXI response
cpu_ar_valid  out  1  request to read master
cpu_ar_ready  in  1  master idle/accepting
cpu_id  out  ID_W  transaction ID
cpu_addr  out  ADDR_W  byte address
cpu_len  out  8  burst length; always 0
cpu_size  out  2  transfer size; IFU always 10
cpu_r_valid  in  1  master data-valid (sticky level, not a pulse)
cpu_r_data  in  DATA_W  byte-lane-masked read data
cpu_r_resp  in  2  read response

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset forces IDLE. Reset also clears all outputs and registers to 0 and sets last_grant=LSU, so the IFU wins the first tie.
- IDLE: the grant is computed combinationally. Only one valid requester: it wins. Both valid: round-robin, the requester not in last_grant wins.
- Granted x_req_ready=1 in IDLE only. On the handshake, addr, size, unsigned and id are latched into cpu_* registers, last_grant is updated, and the FSM goes to ISSUE.
- ISSUE: cpu_ar_valid=1. On cpu_ar_valid & cpu_ar_ready, go to WAIT.
- WAIT: completion strobe = cpu_ar_ready & cpu_r_valid. cpu_r_valid alone is never a completion, because it stays high from earlier transactions. On the strobe, capture data/resp and go to RESP.
- RESP: exactly one cycle with the owner's rsp_valid=1. Return to IDLE; a new grant is possible the next cycle.
- cpu_addr, cpu_size and cpu_id are held constant from the IDLE handshake until RESP exits, because the master samples them every cycle.
- Minimum latency: req handshake at cycle N gives rsp_valid at N+3+memory latency.
- IFU data: ifu_rsp_inst = addr[2] ? data[63:32] : data[31:0].
- LSU data: shift right by addr[2:0]*8, truncate to size, then sign- or zero-extend to 64 bits.
- Misaligned LSU access (crossing an 8-byte boundary) is not supported; the result is undefined. Behaviour is defined only for naturally aligned accesses.
- rsp_* outputs hold their last value when rsp_valid=0.
- Reset mid-transaction returns to IDLE immediately and no response is issued. The read master shares the reset.

Optional Feature:
- Macro YSYX_22041071_RD_TIMEOUT_EN.
- Defined: an 8-bit counter runs in ISSUE and WAIT and is cleared on every state change. If it reaches TIMEOUT_CYC, the FSM forces RESP with resp=2'b11 (DECERR) and data 0, then returns to IDLE. No counter exists otherwise.
- Undefined: the FSM waits indefinitely.

Decomposition:
- Shared define file gets: FSM state encodings, IFU/LSU ID constants, the size encodings, and the DECERR constant.
- One sub-module: ysyx_22041071_ld_align. It is purely combinational, takes data, offset, size and unsigned, and produces the LSU result. The same instance is reused by the write-back path.

Test Plan:
1. IFU request addr 0x8000_0004, mem returns 0x1122_3344_5566_7788 -> cpu_size=10, cpu_id=0, cpu_len=0, ifu_rsp_inst=0x11223344, a single-cycle ifu_rsp_valid.
2. LSU size=00, signed, addr 0x...3, data byte3=0x80 -> lsu_rsp_data=0xFFFF_FFFF_FFFF_FF80; the same access unsigned -> 0x80.
3. IFU and LSU valid together for 4 consecutive requests each -> grants alternate IFU, LSU, IFU, LSU.
4. Stall the master's ar_ready low for 10 cycles in ISSUE -> cpu_addr/cpu_id are stable on every cycle and no rsp_valid is issued.
5. Reset asserted asynchronously during WAIT -> all outputs 0 immediately, FSM in IDLE, no rsp_valid after release.
6. With YSYX_22041071_RD_TIMEOUT_EN and the slave never responding -> rsp_valid after TIMEOUT_CYC cycles with resp=11 and data 0.
